// File: rtl/neuron_pkg.sv
// Shared neuron definitions: FP32 field layout, FP constants, the
// accumulator state encoding and the model / decay-rate codes that the
// decay stage already uses.
package neuron_pkg;

    // FP32 field positions
    localparam int FP32_SIGN_BIT = 31;
    localparam int FP32_EXP_MSB  = 30;
    localparam int FP32_EXP_LSB  = 23;
    localparam int FP32_MAN_MSB  = 22;
    localparam int FP32_EXP_W    = 8;
    localparam int FP32_MAN_W    = 23;

    // FP32 constants
    localparam logic [31:0] FP32_ZERO              = 32'h0000_0000;
    localparam logic [31:0] FP32_MAX               = 32'h7F7F_FFFF;
    localparam logic [31:0] FP32_THRESHOLD_DEFAULT = 32'h41F0_0000; // 30.0

    // Accumulator FSM encoding
    typedef enum logic [1:0] {
        ACC_IDLE    = 2'd0,
        ACC_ACCUM   = 2'd1,
        ACC_COMPARE = 2'd2
    } acc_state_e;

    // Neuron model codes shared with the decay stage
    typedef enum logic [1:0] {
        MODEL_LIF      = 2'd0,
        MODEL_IF       = 2'd1,
        MODEL_ADAPTIVE = 2'd2
    } neuron_model_e;

    // Decay-rate codes shared with the decay stage
    typedef enum logic [1:0] {
        DECAY_HALF      = 2'd0,
        DECAY_QUARTER   = 2'd1,
        DECAY_EIGHTH    = 2'd2,
        DECAY_SIXTEENTH = 2'd3
    } decay_rate_e;

    // Magnitude bits of an FP32 word (sign stripped)
    function automatic logic [30:0] fp32_mag(input logic [31:0] x);
        return x[FP32_EXP_MSB:0];
    endfunction

endpackage

// File: rtl/Addition_Subtraction.sv
// Combinational FP32 adder/subtractor with round-to-nearest-even.
// exception flags an Inf/NaN operand or an exponent overflow; on overflow
// result carries the correctly signed infinity.
module Addition_Subtraction (
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    input  logic        op_sub,
    output logic        exception,
    output logic [31:0] result
);

    logic        sign_a, sign_b, swap, eff_sub, sign_big, overflow;
    logic [30:0] mag_big, mag_sml;
    logic [7:0]  exp_big, exp_sml, exp_diff, exp_field;
    logic [23:0] man_big, man_sml;
    logic [26:0] sml_ext, sml_aligned, norm;
    logic [27:0] big_ext, raw_sum;
    logic [9:0]  exp_work, shift_amt, lz;
    logic        round_up;
    logic [24:0] man_round;
    logic [22:0] frac_out;

    // Align, add/subtract, normalise and round in one combinational pass
    always_comb begin
        sign_a   = a_operand[31];
        sign_b   = b_operand[31] ^ op_sub;
        swap     = (b_operand[30:0] > a_operand[30:0]);
        mag_big  = swap ? b_operand[30:0] : a_operand[30:0];
        mag_sml  = swap ? a_operand[30:0] : b_operand[30:0];
        sign_big = swap ? sign_b : sign_a;
        eff_sub  = sign_a ^ sign_b;

        // Subnormals use exponent 1 with no hidden bit
        exp_big  = (mag_big[30:23] == 8'd0) ? 8'd1 : mag_big[30:23];
        exp_sml  = (mag_sml[30:23] == 8'd0) ? 8'd1 : mag_sml[30:23];
        man_big  = {(mag_big[30:23] != 8'd0), mag_big[22:0]};
        man_sml  = {(mag_sml[30:23] != 8'd0), mag_sml[22:0]};
        exp_diff = exp_big - exp_sml;

        // Three extra bits (guard, round, sticky) below the mantissa
        sml_ext = {man_sml, 3'b000};
        if (exp_diff >= 8'd27) begin
            sml_aligned = {26'd0, |sml_ext};
        end else begin
            sml_aligned = (sml_ext >> exp_diff)
                        | {26'd0, |(sml_ext & ~(27'h7FF_FFFF << exp_diff))};
        end

        big_ext = {1'b0, man_big, 3'b000};
        raw_sum = eff_sub ? (big_ext - {1'b0, sml_aligned})
                          : (big_ext + {1'b0, sml_aligned});

        lz = 10'd27;
        for (int i = 0; i <= 26; i++) begin
            if (raw_sum[i]) lz = 10'(26 - i);
        end

        exp_work  = {2'b00, exp_big};
        shift_amt = 10'd0;
        if (raw_sum[27]) begin
            norm     = {raw_sum[27:2], raw_sum[1] | raw_sum[0]};
            exp_work = exp_work + 10'd1;
        end else begin
            // Never shift below exponent 1: the result becomes subnormal
            shift_amt = (lz < (exp_work - 10'd1)) ? lz : (exp_work - 10'd1);
            norm      = raw_sum[26:0] << shift_amt;
            exp_work  = exp_work - shift_amt;
        end

        round_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
        man_round = {1'b0, norm[26:3]} + {24'd0, round_up};
        if (man_round[24]) begin
            frac_out = man_round[23:1];
            exp_work = exp_work + 10'd1;
        end else begin
            frac_out = man_round[22:0];
        end
        exp_field = (man_round[24] | man_round[23]) ? exp_work[7:0] : 8'd0;
        overflow  = (exp_work >= 10'd255);

        exception = (&a_operand[30:23]) | (&b_operand[30:23]) | overflow;

        if (exception) begin
            result = {sign_big, 8'hFF, 23'd0};
        end else if (raw_sum == 28'd0) begin
            // Exact cancellation gives +0; same-sign zeros keep their sign
            result = {(eff_sub ? 1'b0 : sign_a), 31'd0};
        end else begin
            result = {sign_big, exp_field, frac_out};
        end
    end

endmodule

// File: rtl/fp32_compare_ge.sv
// Combinational signed FP32 compare: ge = (a >= b).
// +0 and -0 compare equal; with differing signs the positive operand wins;
// negative operands order by reversed magnitude. NaNs are not special-cased.
module fp32_compare_ge
    import neuron_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        ge
);

    // Sign-aware ordering of the two operands
    always_comb begin
        ge = 1'b0;
        if ((fp32_mag(a) == 31'd0) && (fp32_mag(b) == 31'd0)) begin
            ge = 1'b1;
        end else if (a[FP32_SIGN_BIT] != b[FP32_SIGN_BIT]) begin
            ge = !a[FP32_SIGN_BIT];
        end else if (!a[FP32_SIGN_BIT]) begin
            ge = (fp32_mag(a) >= fp32_mag(b));
        end else begin
            ge = (fp32_mag(a) <= fp32_mag(b));
        end
    end

endmodule

// File: rtl/potential_accumulator.sv
// Per-neuron FP32 membrane-potential integrator. Loads the decayed
// potential, adds one synaptic weight per handshake, then compares the sum
// against THRESHOLD and returns new_potential (V_RESET on a spike).
// Optional macro SPIKE_COUNT_EN adds a saturating 16-bit spike counter.
//
// Handshake: a weight transfers on a clock edge where weight_valid and
// weight_ready are both high. weight_ready is high throughout ACCUM except
// in the closing cycle (timestep_end high); a weight offered together with
// timestep_end is still accumulated.
module potential_accumulator
    import neuron_pkg::*;
#(
    parameter logic [31:0] THRESHOLD = FP32_THRESHOLD_DEFAULT,
    parameter logic [31:0] V_RESET   = FP32_ZERO,
    parameter logic [31:0] FP_MAX    = FP32_MAX
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        decay_valid,
    input  logic [31:0] decay_potential,
    input  logic        weight_valid,
    input  logic [31:0] weight,
    output logic        weight_ready,
    input  logic        timestep_end,
    output logic [31:0] new_potential,
    output logic        new_potential_valid,
    output logic        spike_out,
    output logic        fp_error,
`ifdef SPIKE_COUNT_EN
    output logic [15:0] spike_count,
`endif
    output acc_state_e  state_dbg
);

    acc_state_e  state_q, state_d;
    logic [31:0] acc_q, add_result, acc_sum, acc_next;
    logic        add_exc, take_weight, close_ts, at_threshold;

    Addition_Subtraction u_adder (
        .a_operand (acc_q),
        .b_operand (weight),
        .op_sub    (1'b0),
        .exception (add_exc),
        .result    (add_result)
    );

    // Compare the value the accumulator will hold after this cycle's add
    fp32_compare_ge u_cmp (
        .a  (acc_next),
        .b  (THRESHOLD),
        .ge (at_threshold)
    );

    assign state_dbg = state_q;

    // Next-state logic, weight_ready and per-cycle strobes
    always_comb begin
        state_d      = state_q;
        weight_ready = 1'b0;
        take_weight  = 1'b0;
        close_ts     = 1'b0;
        case (state_q)
            ACC_IDLE: begin
                if (decay_valid) state_d = ACC_ACCUM;
            end
            ACC_ACCUM: begin
                weight_ready = !timestep_end;
                take_weight  = weight_valid;
                if (timestep_end) begin
                    close_ts = 1'b1;
                    state_d  = ACC_COMPARE;
                end
            end
            ACC_COMPARE: begin
                state_d = ACC_IDLE;
            end
            default: begin
                state_d = ACC_IDLE;
            end
        endcase
    end

    // Saturate on adder exception and select the post-add accumulator value
    always_comb begin
        acc_sum  = add_exc ? {add_result[31], FP_MAX[30:0]} : add_result;
        acc_next = take_weight ? acc_sum : acc_q;
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset) state_q <= ACC_IDLE;
        else        state_q <= state_d;
    end

    // Accumulator, registered outputs and sticky error flag
    always_ff @(posedge clock) begin
        if (!reset) begin
            acc_q               <= FP32_ZERO;
            new_potential       <= FP32_ZERO;
            new_potential_valid <= 1'b0;
            spike_out           <= 1'b0;
            fp_error            <= 1'b0;
        end else begin
            new_potential_valid <= 1'b0;
            spike_out           <= 1'b0;
            if ((state_q == ACC_IDLE) && decay_valid) begin
                acc_q <= decay_potential;
            end else if (take_weight) begin
                acc_q <= acc_sum;
            end
            if (take_weight && add_exc) begin
                fp_error <= 1'b1;
            end
            // Result registered on the closing edge: valid during COMPARE
            if (close_ts) begin
                new_potential_valid <= 1'b1;
                spike_out           <= at_threshold;
                new_potential       <= at_threshold ? V_RESET : acc_next;
            end
        end
    end

`ifdef SPIKE_COUNT_EN
    // Saturating count of emitted spikes
    always_ff @(posedge clock) begin
        if (!reset) begin
            spike_count <= 16'd0;
        end else if (close_ts && at_threshold && (spike_count != 16'hFFFF)) begin
            spike_count <= spike_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_potential_accumulator.sv
// Bench for potential_accumulator: directed cases followed by random
// timesteps of quarter-integer values, checked against an arithmetic model.
module tb_potential_accumulator;
    import neuron_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        decay_valid = 1'b0;
    logic [31:0] decay_potential = 32'd0;
    logic        weight_valid = 1'b0;
    logic [31:0] weight = 32'd0;
    logic        timestep_end = 1'b0;
    logic        weight_ready, new_potential_valid, spike_out, fp_error;
    logic [31:0] new_potential;
    acc_state_e  state_dbg;
`ifdef SPIKE_COUNT_EN
    logic [15:0] spike_count;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    int          exp_spikes = 0;
    logic [31:0] exp_q[$];
    logic [31:0] w_q[$];

    potential_accumulator dut (
        .clock               (clock),
        .reset               (reset),
        .decay_valid         (decay_valid),
        .decay_potential     (decay_potential),
        .weight_valid        (weight_valid),
        .weight              (weight),
        .weight_ready        (weight_ready),
        .timestep_end        (timestep_end),
        .new_potential       (new_potential),
        .new_potential_valid (new_potential_valid),
        .spike_out           (spike_out),
        .fp_error            (fp_error),
`ifdef SPIKE_COUNT_EN
        .spike_count         (spike_count),
`endif
        .state_dbg           (state_dbg)
    );

    // Clock and safety time limit
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Value q/4 as an FP32 word (exact for |q| < 2^24)
    function automatic logic [31:0] q2fp(input int q);
        int          mag;
        int          p;
        logic [31:0] m;
        if (q == 0) return 32'h0000_0000;
        mag = (q < 0) ? -q : q;
        p = 0;
        for (int i = 0; i < 24; i++) if (mag >= (1 << i)) p = i;
        m = 32'(mag) << (23 - p);
        return {(q < 0), 8'(p - 2 + 127), m[22:0]};
    endfunction

    task automatic begin_ts(input logic [31:0] dp);
        @(negedge clock);
        decay_valid = 1'b1;
        decay_potential = dp;
        #1 check_bit("ready_idle", weight_ready, 1'b0);
        @(negedge clock);
        decay_valid = 1'b0;
    endtask

    task automatic feed_weight(input logic [31:0] w);
        weight_valid = 1'b1;
        weight = w;
        #1;
        check_bit("ready_accum", weight_ready, 1'b1);
        check_bit("no_early_valid", new_potential_valid, 1'b0);
        @(negedge clock);
        weight_valid = 1'b0;
    endtask

    // Close the timestep and compare against the head of exp_q
    task automatic finish_ts(input bit has_w, input logic [31:0] w, input logic exp_spike,
                             input string tag);
        logic [31:0] expv;
        timestep_end = 1'b1;
        if (has_w) begin
            weight_valid = 1'b1;
            weight = w;
        end
        #1 check_bit({tag, "_ready_drop"}, weight_ready, 1'b0);
        @(posedge clock);
        #1;
        expv = exp_q.pop_front();
        check_bit({tag, "_valid"}, new_potential_valid, 1'b1);
        check_bit({tag, "_spike"}, spike_out, exp_spike);
        check({tag, "_np"}, new_potential, expv);
        if (exp_spike) exp_spikes++;
        @(negedge clock);
        timestep_end = 1'b0;
        weight_valid = 1'b0;
        @(posedge clock);
        #1;
        check_bit({tag, "_valid_drop"}, new_potential_valid, 1'b0);
        check_bit({tag, "_spike_drop"}, spike_out, 1'b0);
        check({tag, "_np_hold"}, new_potential, expv);
        check({tag, "_idle"}, 32'(state_dbg), 32'(ACC_IDLE));
    endtask

    // Run one timestep from w_q; the last weight may ride on timestep_end
    task automatic run_timestep(input logic [31:0] dp, input bit last_on_end,
                                input logic exp_spike, input string tag);
        logic [31:0] lw;
        begin_ts(dp);
        while (w_q.size() > (last_on_end ? 1 : 0)) begin
            feed_weight(w_q.pop_front());
            if ($urandom_range(0, 3) == 0) @(negedge clock);
        end
        lw = last_on_end ? w_q.pop_front() : 32'd0;
        finish_ts(last_on_end, lw, exp_spike, tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_np"}, new_potential, 32'h0);
        check_bit({tag, "_valid"}, new_potential_valid, 1'b0);
        check_bit({tag, "_spike"}, spike_out, 1'b0);
        check_bit({tag, "_ready"}, weight_ready, 1'b0);
        check_bit({tag, "_fperr"}, fp_error, 1'b0);
        check({tag, "_state"}, 32'(state_dbg), 32'(ACC_IDLE));
`ifdef SPIKE_COUNT_EN
        check({tag, "_count"}, 32'(spike_count), 32'd0);
`endif
    endtask

    initial begin
        int  qd, qw, qsum, nw;
        bit  loe;
        logic spk;

        // Reset
        repeat (2) @(posedge clock);
        #1 check_reset_outputs("reset");
        @(negedge clock);
        reset = 1'b1;

        // Threshold crossing: 8 + 10 + 5 + 10 = 33
        w_q = '{32'h41200000, 32'h40A00000, 32'h41200000};
        exp_q.push_back(32'h00000000);
        run_timestep(32'h41000000, 1'b0, 1'b1, "cross");

        // Sub-threshold: 8 + 10 + 5 = 23
        w_q = '{32'h41200000, 32'h40A00000};
        exp_q.push_back(32'h41B80000);
        run_timestep(32'h41000000, 1'b0, 1'b0, "sub");

        // Negative start, sum exactly 30.0 fires
        w_q = '{32'h42200000, 32'h00000000};
        exp_q.push_back(32'h00000000);
        run_timestep(32'hC1200000, 1'b0, 1'b1, "equal");

        // Weight coincident with timestep_end: 8 + 1 = 9
        w_q = '{32'h3F800000};
        exp_q.push_back(32'h41100000);
        run_timestep(32'h41000000, 1'b1, 1'b0, "coincident");

        // No weights: decayed potential passes through
        w_q.delete();
        exp_q.push_back(32'h41000000);
        run_timestep(32'h41000000, 1'b0, 1'b0, "noweight");

        // Second decay_valid during ACCUM is ignored
        begin_ts(32'h41000000);
        decay_valid = 1'b1;
        decay_potential = 32'h42C80000;
        feed_weight(32'h3F800000);
        decay_valid = 1'b0;
        exp_q.push_back(32'h41100000);
        finish_ts(1'b0, 32'd0, 1'b0, "decay_ignored");

        // timestep_end while IDLE is ignored
        @(negedge clock);
        timestep_end = 1'b1;
        @(posedge clock);
        #1 check_bit("idle_end_valid", new_potential_valid, 1'b0);
        check("idle_end_state", 32'(state_dbg), 32'(ACC_IDLE));
        @(negedge clock);
        timestep_end = 1'b0;

        // Random timesteps of quarter-integer values
        for (int t = 0; t < 40; t++) begin
            qd = int'($urandom_range(0, 320)) - 160;
            nw = int'($urandom_range(0, 5));
            qsum = qd;
            w_q.delete();
            for (int k = 0; k < nw; k++) begin
                qw = int'($urandom_range(0, 160)) - 80;
                w_q.push_back(q2fp(qw));
                qsum += qw;
            end
            loe = (nw > 0) && ($urandom_range(0, 1) == 1);
            spk = (qsum >= 120);
            exp_q.push_back(spk ? 32'h0 : q2fp(qsum));
            run_timestep(q2fp(qd), loe, spk, "rand");
            if ($urandom_range(0, 2) == 0) @(negedge clock);
        end
        check_bit("rand_fperr", fp_error, 1'b0);
`ifdef SPIKE_COUNT_EN
        check("rand_count", 32'(spike_count), 32'(exp_spikes));
`endif

        // Positive overflow saturates to FP_MAX, fires, sets fp_error
        w_q = '{32'h7F7FFFFF};
        exp_q.push_back(32'h00000000);
        run_timestep(32'h7F7FFFFF, 1'b0, 1'b1, "ovf_pos");
        check_bit("ovf_fperr", fp_error, 1'b1);

        // Negative overflow saturates to -FP_MAX, no spike
        w_q = '{32'hFF7FFFFF};
        exp_q.push_back(32'hFF7FFFFF);
        run_timestep(32'hFF7FFFFF, 1'b0, 1'b0, "ovf_neg");

        // fp_error stays set through a clean timestep
        w_q = '{32'h41200000, 32'h40A00000};
        exp_q.push_back(32'h41B80000);
        run_timestep(32'h41000000, 1'b0, 1'b0, "sticky");
        check_bit("sticky_fperr", fp_error, 1'b1);

        // Reset mid-ACCUM after two weights
        begin_ts(32'h41000000);
        feed_weight(32'h41200000);
        feed_weight(32'h40A00000);
        reset = 1'b0;
        exp_spikes = 0;
        @(posedge clock);
        #1 check_reset_outputs("midreset");
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1 check_bit("midreset_novalid", new_potential_valid, 1'b0);

        // Next timestep after reset, then three spiking timesteps
        w_q = '{32'h41200000, 32'h40A00000};
        exp_q.push_back(32'h41B80000);
        run_timestep(32'h41000000, 1'b0, 1'b0, "post_reset");
        for (int s = 0; s < 3; s++) begin
            w_q = '{32'h41200000, 32'h40A00000, 32'h41200000};
            exp_q.push_back(32'h00000000);
            run_timestep(32'h41000000, 1'b0, 1'b1, "spike3");
        end
`ifdef SPIKE_COUNT_EN
        check("spike_count3", 32'(spike_count), 32'd3);
`endif
        check_bit("final_fperr", fp_error, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
